// File: rtl/fsm_channel_arbiter.sv
// ============================================================================
// Module   : fsm_channel_arbiter
// Purpose  : Four-way round-robin arbiter with a hold limit and a one-cycle
//            turnaround between owners of the shared FSM input channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_channel_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] Req,
    output logic [3:0] Gnt,
    output logic       Gnt_Valid,
    output logic [1:0] Gnt_Id,
    output logic       Timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        TURN  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_gnt;
    logic             r_gnt_valid;
    logic [1:0]       r_gnt_id;
    logic             r_timeout;

    logic [1:0]       w_pick_id;
    logic [3:0]       w_pick_onehot;

    // Scan from the highest offset down so the bit nearest r_ptr wins.
    always_comb begin
        logic [1:0] v_idx;
        w_pick_id = r_ptr;
        v_idx     = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            v_idx = r_ptr + 2'(i);
            if (Req[v_idx]) begin
                w_pick_id = v_idx;
            end
        end
        w_pick_onehot = 4'b0001 << w_pick_id;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_ptr       <= 2'b00;
            r_cnt       <= '0;
            r_gnt       <= 4'b0000;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= 2'b00;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    if (|Req) begin
                        r_gnt       <= w_pick_onehot;
                        r_gnt_id    <= w_pick_id;
                        r_gnt_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_ptr       <= w_pick_id + 2'd1;
                        r_state     <= GRANT;
                    end else begin
                        r_gnt       <= 4'b0000;
                        r_gnt_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    // A dropped request takes precedence over the hold limit.
                    if (!Req[r_gnt_id]) begin
                        r_gnt       <= 4'b0000;
                        r_gnt_valid <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_state     <= TURN;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_gnt       <= 4'b0000;
                        r_gnt_valid <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_state     <= TURN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                TURN: begin
                    r_gnt       <= 4'b0000;
                    r_gnt_valid <= 1'b0;
                    r_timeout   <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_gnt       <= 4'b0000;
                    r_gnt_valid <= 1'b0;
                    r_gnt_id    <= 2'b00;
                    r_timeout   <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign Gnt       = r_gnt;
    assign Gnt_Valid = r_gnt_valid;
    assign Gnt_Id    = r_gnt_id;
    assign Timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_fsm_channel_arbiter.sv
// ============================================================================
// Module   : tb_fsm_channel_arbiter
// Purpose  : Scoreboard bench for fsm_channel_arbiter with directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_channel_arbiter;

    localparam int MAX_HOLD = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] Req = 4'b0000;
    logic [3:0] Gnt;
    logic       Gnt_Valid;
    logic [1:0] Gnt_Id;
    logic       Timeout;

    fsm_channel_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Req       (Req),
        .Gnt       (Gnt),
        .Gnt_Valid (Gnt_Valid),
        .Gnt_Id    (Gnt_Id),
        .Timeout   (Timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] gnt;
        logic       valid;
        logic [1:0] id;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: phase 0 idle, 1 granted, 2 turnaround.
    int   m_phase = 0;
    int   m_owner = 0;
    int   m_next  = 0;
    int   m_held  = 0;
    exp_t m_out   = '{gnt: 4'b0000, valid: 1'b0, id: 2'b00, to: 1'b0};

    int   order[$];
    int   to_count = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic rst, input logic [3:0] req);
        if (rst) begin
            m_phase = 0; m_owner = 0; m_next = 0; m_held = 0;
            m_out = '{gnt: 4'b0000, valid: 1'b0, id: 2'b00, to: 1'b0};
        end else if (m_phase == 0) begin
            m_out.to = 1'b0;
            if (req != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_phase == 0 && req[(m_next + i) % 4]) begin
                        m_owner = (m_next + i) % 4;
                        m_phase = 1;
                    end
                end
                m_next    = (m_owner + 1) % 4;
                m_held    = 1;
                m_out.gnt = 4'(1 << m_owner);
                m_out.id  = 2'(m_owner);
                m_out.valid = 1'b1;
            end else begin
                m_out.gnt = 4'b0000;
                m_out.valid = 1'b0;
            end
        end else if (m_phase == 1) begin
            if (!req[m_owner]) begin
                m_phase = 2; m_out.gnt = 4'b0000; m_out.valid = 1'b0; m_out.to = 1'b0;
            end else if (m_held == MAX_HOLD) begin
                m_phase = 2; m_out.gnt = 4'b0000; m_out.valid = 1'b0; m_out.to = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            m_phase = 0; m_out.to = 1'b0;
        end
    endtask

    task automatic step(input logic [3:0] req, input logic rst);
        exp_t e;
        @(negedge CLK);
        Req = req;
        RST = rst;
        model(rst, req);
        sb.push_back(m_out);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk("gnt",       {4'b0, Gnt},       {4'b0, e.gnt});
        chk("gnt_valid", {7'b0, Gnt_Valid}, {7'b0, e.valid});
        chk("gnt_id",    {6'b0, Gnt_Id},    {6'b0, e.id});
        chk("timeout",   {7'b0, Timeout},   {7'b0, e.to});
        if (Gnt_Valid && !prev_valid) order.push_back(int'(Gnt_Id));
        if (Timeout) to_count++;
        prev_valid = Gnt_Valid;
    endtask

    initial begin
        // Reset held with all requesters active.
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1);
        chk("reset_gnt", {4'b0, Gnt}, 8'h00);

        // Round robin with all four requesting.
        order.delete();
        to_count = 0;
        for (int i = 0; i < 50; i++) step(4'b1111, 1'b0);
        chk("rr_count", 8'(order.size()), 8'd5);
        if (order.size() == 5) begin
            chk("rr_0", 8'(order[0]), 8'd0);
            chk("rr_1", 8'(order[1]), 8'd1);
            chk("rr_2", 8'(order[2]), 8'd2);
            chk("rr_3", 8'(order[3]), 8'd3);
            chk("rr_4", 8'(order[4]), 8'd0);
        end
        chk("rr_timeouts", 8'(to_count), 8'd5);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);

        // Single short request, then next arbitration starts at 3.
        for (int i = 0; i < 3; i++) begin
            step(4'b0100, 1'b0);
            chk("short_gnt", {4'b0, Gnt}, 8'h04);
        end
        step(4'b0000, 1'b0);
        chk("short_rel", {4'b0, Gnt}, 8'h00);
        chk("short_to", {7'b0, Timeout}, 8'h00);
        step(4'b0000, 1'b0);
        step(4'b1111, 1'b0);
        chk("ptr3_id", {6'b0, Gnt_Id}, 8'd3);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);

        // Priority skip: serve 1, then 0011 wraps to 0.
        step(4'b0010, 1'b0);
        chk("serve1_id", {6'b0, Gnt_Id}, 8'd1);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);
        step(4'b0011, 1'b0);
        chk("skip_id", {6'b0, Gnt_Id}, 8'd0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);

        // Drop on the edge the hold limit is reached.
        for (int i = 0; i < MAX_HOLD; i++) step(4'b0001, 1'b0);
        chk("tie_pre_gnt", {4'b0, Gnt}, 8'h01);
        step(4'b0000, 1'b0);
        chk("tie_gnt", {4'b0, Gnt}, 8'h00);
        chk("tie_to", {7'b0, Timeout}, 8'h00);
        for (int i = 0; i < 2; i++) step(4'b0000, 1'b0);

        // Reset mid-grant with requester 3 owning at count 3.
        for (int i = 0; i < 4; i++) step(4'b1000, 1'b0);
        chk("mid_gnt", {4'b0, Gnt}, 8'h08);
        step(4'b1001, 1'b1);
        chk("rst_gnt", {4'b0, Gnt}, 8'h00);
        chk("rst_to", {7'b0, Timeout}, 8'h00);
        step(4'b1001, 1'b0);
        chk("post_rst_id", {6'b0, Gnt_Id}, 8'd0);
        for (int i = 0; i < 20; i++) step(4'b1001, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);

        // One requester holding forever: 8 on, 2 off, repeating.
        to_count = 0;
        for (int i = 0; i < 30; i++) step(4'b0100, 1'b0);
        chk("solo_timeouts", 8'(to_count), 8'd3);

        // Random traffic with occasional resets.
        for (int i = 0; i < 120; i++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fsm_channel_arbiter.md
# fsm_channel_arbiter

Round-robin arbiter that shares one pulse-detect FSM input channel among four requesters. Each requester raises its request line. The arbiter grants exactly one requester at a time, holds the grant while that request stays high, and force-releases it after a configurable maximum hold. A fixed turnaround gap separates consecutive grants so the downstream FSM never sees back-to-back owners.

## Interface
- MAX_HOLD, default 8: maximum consecutive grant cycles per owner; legal range 2..255.
- CNT_W, default 8: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

- CLK: input, 1 bit. Single clock; all state updates on rising edge.
- RST: input, 1 bit. Reset is synchronous and active-high, sampled on rising edge of CLK.
- Req: input, 4 bits. Request per requester; level-sensitive.
- Gnt: output, 4 bits. One-hot grant; all zero when no owner. Registered.
- Gnt_Valid: output, 1 bit. High whenever Gnt is nonzero. Registered.
- Gnt_Id: output, 2 bits. Index of current owner. Holds the last owner when Gnt_Valid=0. Registered.
- Timeout: output, 1 bit. One-cycle pulse: the previous grant ended by hold limit, not by request drop. Registered.

## Operation
- States: IDLE, GRANT, TURN. Encoding 2'b00, 2'b01, 2'b10. Unused encoding 2'b11 goes to IDLE with all outputs cleared.
- Internal regs: Ptr (2 bits, rotating priority start) and Cnt (CNT_W bits, hold counter).
- IDLE:
  - If Req==0: stay; all outputs 0.
  - Else: scan Req from index Ptr upward, mod 4, and pick the first set bit k.
  - Set Gnt=1<<k, Gnt_Id=k, Gnt_Valid=1, Cnt=0, Ptr=(k+1) mod 4. Go to GRANT.
- GRANT, evaluated every edge, in priority order:
  - Req[Gnt_Id]==0: clear Gnt/Gnt_Valid, Timeout=0, go to TURN.
  - Else if Cnt==MAX_HOLD-1: clear Gnt/Gnt_Valid, Timeout=1, go to TURN.
  - Else: Cnt=Cnt+1. Grant unchanged.
  - Requests from non-owners are ignored during GRANT.
- TURN: exactly one cycle. Gnt=0, Timeout cleared. Unconditionally go to IDLE. No arbitration occurs in TURN.
- Priority rotation:
  - A requester that just held the grant has the lowest priority at the next arbitration.
  - With all four requesting continuously, grant order is 0,1,2,3,0,...
- Counter:
  - Cnt never exceeds MAX_HOLD-1.
  - Cnt does not wrap, and is not written outside IDLE→GRANT and GRANT.

## Timing
- Reset values: state=IDLE, Gnt=4'b0000, Gnt_Valid=0, Gnt_Id=2'b00, Timeout=0, Ptr=0, Cnt=0.
- RST mid-grant: Gnt drops on the same edge RST is sampled high. No Timeout pulse. Ptr returns to 0.
- Grant latency: Req sampled high at edge E in IDLE → Gnt high from E until the releasing edge.
- Maximum grant length: MAX_HOLD cycles of Gnt high.
- Grant length on request drop: Req[k] low sampled at edge E → Gnt low after E. The owner sees Gnt high for one cycle after its last high Req sample.
- Gap between grants: minimum two cycles of Gnt=0 (TURN, then IDLE).
- Timeout: high exactly during the TURN cycle following a limit release.
- Owner request dropping on the same edge the limit is reached: the request-drop rule wins; Timeout=0.
- Single requester holding Req high forever: grant pattern is MAX_HOLD cycles on, 2 off, repeating, with Timeout pulsing each period.
- Gnt, Gnt_Valid, and Gnt_Id always change on the same edge. Gnt is never multi-hot.

## Test plan
- Reset: drive Req=4'b1111 with RST=1 for 3 cycles → Gnt=0, Gnt_Valid=0, Timeout=0 throughout. First grant is to requester 0 one edge after RST deasserts.
- Single short request: Req=4'b0100 held for 3 edges, then dropped → Gnt=4'b0100 for 3 cycles, then 2 zero cycles, Timeout=0. Next arbitration starts at Ptr=3.
- Round-robin: Req=4'b1111 constant, MAX_HOLD=8 → Gnt_Id sequence 0,1,2,3,0. Each grant lasts 8 cycles with a 2-cycle gap, and Timeout pulses once per grant.
- Priority skip: after requester 1 is served, Req=4'b0011 → grant goes to 0, because the scan from Ptr=2 wraps past 2 and 3 to 0.
- Drop-at-limit tie: the owner drops Req on the edge where Cnt==MAX_HOLD-1 → Gnt clears and Timeout=0.
- Reset mid-grant: assert RST while Gnt=4'b1000 at Cnt=3 → Gnt=0 on the next edge, no Timeout, Ptr=0. With Req=4'b1001 held, the post-reset grant goes to 0.
